// File: rtl/systolic_array_ctrl_if.sv
`timescale 1ns/1ps
// Bundles the burst-control, operand-stream, array-edge and result signals of systolic_array_ctrl.
// slave = controller side; master = everything around it (host streams and array fabric).
interface systolic_array_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8
) ();
  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic                    a_valid;
  logic                    a_ready;
  logic [4*DATA_WIDTH-1:0] a_data;
  logic                    b_valid;
  logic                    b_ready;
  logic [4*DATA_WIDTH-1:0] b_data;
  logic [3:0]              arr_en_left;
  logic [4*DATA_WIDTH-1:0] arr_data_left;
  logic [3:0]              arr_en_up;
  logic [4*DATA_WIDTH-1:0] arr_data_up;
  logic [3:0]              arr_en_down;
  logic [4*DATA_WIDTH-1:0] arr_data_down;
  logic [3:0]              res_valid;
  logic [4*DATA_WIDTH-1:0] res_data;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, cfg_len, a_valid, a_data, b_valid, b_data, arr_en_down, arr_data_down,
    output a_ready, b_ready, arr_en_left, arr_data_left, arr_en_up, arr_data_up,
           res_valid, res_data, busy, done
  );

  modport master (
    output start, cfg_len, a_valid, a_data, b_valid, b_data, arr_en_down, arr_data_down,
    input  a_ready, b_ready, arr_en_left, arr_data_left, arr_en_up, arr_data_up,
           res_valid, res_data, busy, done
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
`timescale 1ns/1ps
// Burst controller for a 4x4 systolic array: joint A/B beat acceptance, per-lane input skew, drain and result capture.
// Optional SA_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module systolic_array_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 10
) (
  input  logic                 ctrl_clk,
  input  logic                 ctrl_rst_n,
  systolic_array_ctrl_if.slave bus
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_busy_cyc,
  output logic [31:0]          perf_stall_cyc
`endif
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0]              res_valid_q, res_valid_d;
  logic [4*DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                    accept;

  // A beat moves only when both operand streams present together.
  assign accept      = (state_q == ST_FEED) && bus.a_valid && bus.b_valid;
  assign bus.a_ready = accept;
  assign bus.b_ready = accept;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          beat_cnt_d = bus.cfg_len;
          state_d    = (bus.cfg_len != '0) ? ST_FEED : ST_DONE;
        end
      end
      ST_FEED: begin
        if (accept && (beat_cnt_q != '0)) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            drain_cnt_d = DRN_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_DONE;
        else                   drain_cnt_d = drain_cnt_q - DRN_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Result capture: data is masked so idle lanes always read zero.
  always_comb begin
    res_valid_d = bus.arr_en_down;
    res_data_d  = '0;
    for (int j = 0; j < 4; j++) begin
      if (bus.arr_en_down[j]) res_data_d[j*DATA_WIDTH +: DATA_WIDTH] = bus.arr_data_down[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

  // Lane i carries i+1 stages so row/column i sees the beat i cycles after lane 0; idle cycles shift in as zero bubbles.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [i:0]                 left_en_q, left_en_d, up_en_q, up_en_d;
    logic [i:0][DATA_WIDTH-1:0] left_dat_q, left_dat_d, up_dat_q, up_dat_d;

    always_comb begin
      left_en_d     = left_en_q;
      up_en_d       = up_en_q;
      left_dat_d    = left_dat_q;
      up_dat_d      = up_dat_q;
      left_en_d[0]  = accept;
      up_en_d[0]    = accept;
      left_dat_d[0] = accept ? bus.a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      up_dat_d[0]   = accept ? bus.b_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int k = 1; k <= i; k++) begin
        left_en_d[k]  = left_en_q[k-1];
        up_en_d[k]    = up_en_q[k-1];
        left_dat_d[k] = left_dat_q[k-1];
        up_dat_d[k]   = up_dat_q[k-1];
      end
    end

    always_ff @(posedge ctrl_clk) begin
      if (!ctrl_rst_n) begin
        left_en_q  <= '0;
        up_en_q    <= '0;
        left_dat_q <= '0;
        up_dat_q   <= '0;
      end else begin
        left_en_q  <= left_en_d;
        up_en_q    <= up_en_d;
        left_dat_q <= left_dat_d;
        up_dat_q   <= up_dat_d;
      end
    end

    assign bus.arr_en_left[i]                             = left_en_q[i];
    assign bus.arr_en_up[i]                               = up_en_q[i];
    assign bus.arr_data_left[i*DATA_WIDTH +: DATA_WIDTH] = left_dat_q[i];
    assign bus.arr_data_up[i*DATA_WIDTH +: DATA_WIDTH]   = up_dat_q[i];
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
  logic        launch;

  assign launch = (state_q == ST_IDLE) && bus.start;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (launch) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_q && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
      if ((state_q == ST_FEED) && !accept && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of one array operand lane.
REQ-002 The block SHALL have parameter LEN_W, default 8, the width of the burst-length field.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 10, the number of flush cycles after the last accepted beat.
REQ-004 The block SHALL have port ctrl_clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have port ctrl_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle burst launch pulse.
REQ-007 The block SHALL have port cfg_len, input, LEN_W bits: the number of beats in the burst, sampled with start.
REQ-008 The block SHALL have ports a_valid (input, 1), a_ready (output, 1) and a_data (input, 4*DATA_WIDTH): the row-operand stream, with lane i feeding array row i.
REQ-009 The block SHALL have ports b_valid (input, 1), b_ready (output, 1) and b_data (input, 4*DATA_WIDTH): the column-operand stream, with lane j feeding array column j.
REQ-010 The block SHALL have ports arr_en_left (output, 4) and arr_data_left (output, 4*DATA_WIDTH): the skewed left-edge drive, bit/lane i to row i.
REQ-011 The block SHALL have ports arr_en_up (output, 4) and arr_data_up (output, 4*DATA_WIDTH): the skewed top-edge drive, bit/lane j to column j.
REQ-012 The block SHALL have ports arr_en_down (input, 4) and arr_data_down (input, 4*DATA_WIDTH): the bottom-row outputs of the array.
REQ-013 The block SHALL have ports res_valid (output, 4) and res_data (output, 4*DATA_WIDTH): the registered result capture, per column.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle burst-complete pulse.

Function
REQ-016 The controller SHALL implement a four-state FSM: IDLE, FEED, DRAIN, DONE.
REQ-017 In IDLE, start=1 SHALL latch cfg_len into the beat counter and move the FSM to FEED when cfg_len>0, or to DONE when cfg_len=0.
REQ-018 Outside IDLE, start SHALL be ignored.
REQ-019 In FEED, a_ready and b_ready SHALL both equal a_valid AND b_valid, so a beat is accepted only when both streams are valid in the same cycle.
REQ-020 Outside FEED, a_ready and b_ready SHALL be 0.
REQ-021 Each accepted beat SHALL decrement the beat counter; acceptance of the final beat SHALL move the FSM to DRAIN.
REQ-022 Skew: a beat accepted in cycle t SHALL drive arr_en_left[i]=1 with arr_data_left lane i = a_data lane i in cycle t+1+i.
REQ-023 Skew: a beat accepted in cycle t SHALL drive arr_en_up[j]=1 with arr_data_up lane j = b_data lane j in cycle t+1+j.
REQ-024 A cycle with no accepted beat SHALL propagate through the skew pipeline as a bubble, i.e. en=0 and data=0 on that lane at the delayed time.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles and then move the FSM to DONE.
REQ-026 The skew pipeline SHALL keep shifting during DRAIN.
REQ-027 DONE SHALL last one cycle with done=1 and then move the FSM to IDLE.
REQ-028 In every state, res_valid[j] and res_data lane j SHALL equal arr_en_down[j] and arr_data_down lane j registered one cycle earlier.
REQ-029 res_data lane j SHALL be 0 whenever res_valid[j] is 0.
REQ-030 A start pulse in the same cycle as done SHALL be ignored, because the FSM is not yet in IDLE.
REQ-031 The beat counter SHALL be LEN_W bits wide and SHALL never wrap, since it is only decremented on acceptance while non-zero.

Reset
REQ-032 When ctrl_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and the beat counter and DRAIN counter SHALL clear.
REQ-033 When ctrl_rst_n=0 at a clock edge, all skew registers SHALL clear, so every arr_en_*=0 and every arr_data_*=0.
REQ-034 When ctrl_rst_n=0 at a clock edge, res_valid, res_data, a_ready, b_ready, busy and done SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no done pulse, and the skew pipeline SHALL hold no residual enables afterwards.

Configuration
REQ-036 With macro SA_CTRL_PERF_EN defined, the block SHALL add output perf_busy_cyc (32 bits), counting cycles with busy=1.
REQ-037 With SA_CTRL_PERF_EN defined, the block SHALL add output perf_stall_cyc (32 bits), counting FEED cycles with no accepted beat.
REQ-038 Both performance counters SHALL clear on reset and on every start accepted in IDLE, and SHALL saturate at all-ones.
REQ-039 Without SA_CTRL_PERF_EN, the perf_busy_cyc and perf_stall_cyc ports and their logic SHALL be absent.

Verification
REQ-040 Bench SHALL cover: start with cfg_len=1, both streams valid, accepted at cycle 1 -> arr_en_left[0] high at cycle 2 and arr_en_left[3] high at cycle 5; done at cycle 2+DRAIN_CYCLES; busy low the cycle after.
REQ-041 Bench SHALL cover: cfg_len=4 with b_valid withheld for 2 cycles after the second beat -> a_ready=0 during the gap; bubbles appear on all lanes, skewed by lane index; exactly 4 enables per lane.
REQ-042 Bench SHALL cover: start with cfg_len=0 -> done one cycle later, no ready and no enables asserted.
REQ-043 Bench SHALL cover: start pulsed during FEED and again in the DONE cycle -> both ignored; beat count unchanged.
REQ-044 Bench SHALL cover: ctrl_rst_n driven low for one cycle mid-FEED after 2 of 4 beats -> next cycle all outputs 0, state IDLE, no done; a new start with cfg_len=2 completes normally.
REQ-045 Bench SHALL cover: arr_en_down=4'b1010 with lane data 0x11,0x22,0x33,0x44 -> the next cycle res_valid=4'b1010, lanes 1 and 3 = 0x22 and 0x44, lanes 0 and 2 = 0.
